// File: rtl/dac_perturb_sequencer_pkg.sv
// Shared types and helpers for the SPGD DAC perturbation path:
// FSM encoding, sign-LFSR constants and DAC-code saturation.
package dac_perturb_sequencer_pkg;

  localparam int DAC_W  = 14;
  localparam int LFSR_W = 16;

  localparam logic [LFSR_W-1:0] LFSR_TAP_MASK = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_DEFAULT  = 16'hACE1;

  localparam logic signed [DAC_W+1:0] SAT_MAX = (DAC_W+2)'(2**(DAC_W-1) - 1);
  localparam logic signed [DAC_W+1:0] SAT_MIN = (DAC_W+2)'(-(2**(DAC_W-1)));

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE_P,
    ST_HOLD_P,
    ST_SETTLE_M,
    ST_HOLD_M,
    ST_FIN
  } state_t;

  // Clamp a two-guard-bit intermediate sum to the signed DAC code range.
  function automatic logic [DAC_W-1:0] sat_dac(input logic signed [DAC_W+1:0] v);
    if (v > SAT_MAX) return SAT_MAX[DAC_W-1:0];
    if (v < SAT_MIN) return SAT_MIN[DAC_W-1:0];
    return v[DAC_W-1:0];
  endfunction

endpackage

// File: rtl/dac_perturb_sequencer_lfsr.sv
// Galois sign generator for SPGD perturbations: right shift, tap mask
// applied when the shifted-out bit is 1; a zero seed is never loaded.
module spgd_sign_lfsr
  import dac_perturb_sequencer_pkg::*;
#(
  parameter int                LFSR_WIDTH   = LFSR_W,
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = dac_perturb_sequencer_pkg::LFSR_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic [LFSR_WIDTH-1:0] i_seed,
  input  logic                  i_step,
  output logic                  o_bit,
  output logic [LFSR_WIDTH-1:0] o_state
);

  logic [LFSR_WIDTH-1:0] r_lfsr;
  logic [LFSR_WIDTH-1:0] w_next;

  assign w_next  = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAP_MASK : '0);
  assign o_bit   = r_lfsr[0];
  assign o_state = r_lfsr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= SEED_DEFAULT;
    end else if (i_load) begin
      r_lfsr <= (i_seed == '0) ? SEED_DEFAULT : i_seed;
    end else if (i_step) begin
      r_lfsr <= w_next;
    end
  end

endmodule

// File: rtl/dac_perturb_sequencer.sv
// Drives BASE+s*DELTA then BASE-s*DELTA, each with a settle and a hold
// interval; AVE_EN frames the holds so the ADC averager sees settled data.
module dac_perturb_sequencer
  import dac_perturb_sequencer_pkg::*;
#(
  parameter int                DAC_WIDTH    = DAC_W,
  parameter int                CNT_WIDTH    = 32,
  parameter int                LFSR_WIDTH   = LFSR_W,
  parameter logic [LFSR_W-1:0] LFSR_DEFAULT = dac_perturb_sequencer_pkg::LFSR_DEFAULT
) (
  input  logic                  ADC_CLK,
  input  logic                  ADC_RSTN,
  input  logic                  START,
  input  logic                  ABORT,
  input  logic [CNT_WIDTH-1:0]  TIMER_OFFSET,
  input  logic [CNT_WIDTH-1:0]  TIME_VALUE,
  input  logic [DAC_WIDTH-1:0]  BASE_CODE,
  input  logic [DAC_WIDTH-1:0]  DELTA_CODE,
  input  logic [LFSR_WIDTH-1:0] SEED,
  input  logic                  SEED_LOAD,
  output logic [DAC_WIDTH-1:0]  DAC_CODE_OUT,
  output logic                  AVE_EN,
  output logic                  PHASE,
  output logic                  SIGN,
  output logic                  BUSY,
  output logic                  DONE,
  output state_t                DBG_STATE,
  output logic [LFSR_WIDTH-1:0] DBG_LFSR
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  state_t                 r_state;
  logic [CNT_WIDTH-1:0]   r_offset, r_time, r_cnt;
  logic [DAC_WIDTH-1:0]   r_base, r_delta, r_dac;
  logic                   r_ave, r_phase, r_sign, r_busy, r_done;

  logic                   w_lfsr_bit, w_seed_load, w_step;
  logic [CNT_WIDTH-1:0]   w_time_in;
  logic signed [DAC_WIDTH+1:0] w_base_in, w_delta_in, w_base_lat, w_delta_lat;
  logic signed [DAC_WIDTH+1:0] w_sum_p, w_sum_m;
  logic [DAC_WIDTH-1:0]   w_code_p, w_code_m;

  // START is a one-cycle request honoured only in IDLE with ABORT low; there
  // is no back-pressure, a request seen while BUSY is simply dropped.
  assign w_seed_load = SEED_LOAD && (r_state == ST_IDLE);
  assign w_step      = (r_state == ST_FIN) && !ABORT;
  assign w_time_in   = (TIME_VALUE == '0) ? ONE : TIME_VALUE;

  assign w_base_in   = {{2{BASE_CODE[DAC_WIDTH-1]}}, BASE_CODE};
  assign w_delta_in  = {2'b00, DELTA_CODE};
  assign w_base_lat  = {{2{r_base[DAC_WIDTH-1]}}, r_base};
  assign w_delta_lat = {2'b00, r_delta};
  assign w_sum_p     = w_lfsr_bit ? (w_base_in - w_delta_in) : (w_base_in + w_delta_in);
  assign w_sum_m     = r_sign ? (w_base_lat + w_delta_lat) : (w_base_lat - w_delta_lat);
  assign w_code_p    = sat_dac(w_sum_p);
  assign w_code_m    = sat_dac(w_sum_m);

  spgd_sign_lfsr #(
    .LFSR_WIDTH   (LFSR_WIDTH),
    .SEED_DEFAULT (LFSR_DEFAULT)
  ) u_lfsr (
    .i_clk   (ADC_CLK),
    .i_rst_n (ADC_RSTN),
    .i_load  (w_seed_load),
    .i_seed  (SEED),
    .i_step  (w_step),
    .o_bit   (w_lfsr_bit),
    .o_state (DBG_LFSR)
  );

  always_ff @(posedge ADC_CLK or negedge ADC_RSTN) begin
    if (!ADC_RSTN) begin
      r_state  <= ST_IDLE;
      r_offset <= '0;
      r_time   <= '0;
      r_cnt    <= '0;
      r_base   <= '0;
      r_delta  <= '0;
      r_dac    <= '0;
      r_ave    <= 1'b0;
      r_phase  <= 1'b0;
      r_sign   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (ABORT) begin
      if (r_state != ST_IDLE) begin
        r_state <= ST_IDLE;
        r_dac   <= r_base;
        r_ave   <= 1'b0;
        r_phase <= 1'b0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (START) begin
            r_offset <= TIMER_OFFSET;
            r_time   <= w_time_in;
            r_base   <= BASE_CODE;
            r_delta  <= DELTA_CODE;
            r_sign   <= w_lfsr_bit;
            r_dac    <= w_code_p;
            r_phase  <= 1'b0;
            r_busy   <= 1'b1;
            if (TIMER_OFFSET == '0) begin
              r_state <= ST_HOLD_P;
              r_cnt   <= w_time_in - ONE;
              r_ave   <= 1'b1;
            end else begin
              r_state <= ST_SETTLE_P;
              r_cnt   <= TIMER_OFFSET - ONE;
            end
          end
        end
        ST_SETTLE_P, ST_SETTLE_M: begin
          if (r_cnt == '0) begin
            r_state <= (r_state == ST_SETTLE_P) ? ST_HOLD_P : ST_HOLD_M;
            r_cnt   <= r_time - ONE;
            r_ave   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - ONE;
          end
        end
        ST_HOLD_P: begin
          if (r_cnt == '0) begin
            r_dac   <= w_code_m;
            r_phase <= 1'b1;
            // With no settle interval the averaging window runs straight on.
            if (r_offset == '0) begin
              r_state <= ST_HOLD_M;
              r_cnt   <= r_time - ONE;
            end else begin
              r_state <= ST_SETTLE_M;
              r_cnt   <= r_offset - ONE;
              r_ave   <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - ONE;
          end
        end
        ST_HOLD_M: begin
          if (r_cnt == '0) begin
            r_state <= ST_FIN;
            r_dac   <= r_base;
            r_ave   <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - ONE;
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_phase <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_ave   <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign DAC_CODE_OUT = r_dac;
  assign AVE_EN       = r_ave;
  assign PHASE        = r_phase;
  assign SIGN         = r_sign;
  assign BUSY         = r_busy;
  assign DONE         = r_done;
  assign DBG_STATE    = r_state;

endmodule

// File: tb/tb_dac_perturb_sequencer.sv
// Bench for dac_perturb_sequencer: per-cycle expected output words are
// queued when a sequence is launched and compared as the DUT produces them.
module tb_dac_perturb_sequencer;
  import dac_perturb_sequencer_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start, abort, seed_load;
  logic [31:0] timer_offset, time_value;
  logic [13:0] base_code, delta_code;
  logic [15:0] seed;
  logic [13:0] dac_code_out;
  logic        ave_en, phase, sign, busy, done;
  state_t      dbg_state;
  logic [15:0] dbg_lfsr;

  dac_perturb_sequencer dut (
    .ADC_CLK      (clk),
    .ADC_RSTN     (rst_n),
    .START        (start),
    .ABORT        (abort),
    .TIMER_OFFSET (timer_offset),
    .TIME_VALUE   (time_value),
    .BASE_CODE    (base_code),
    .DELTA_CODE   (delta_code),
    .SEED         (seed),
    .SEED_LOAD    (seed_load),
    .DAC_CODE_OUT (dac_code_out),
    .AVE_EN       (ave_en),
    .PHASE        (phase),
    .SIGN         (sign),
    .BUSY         (busy),
    .DONE         (done),
    .DBG_STATE    (dbg_state),
    .DBG_LFSR     (dbg_lfsr)
  );

  // scoreboard state: output word = {dac, ave_en, phase, sign, busy, done}
  logic [18:0] exp_q[$];
  logic [15:0] m_lfsr;
  int          last_base;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] outs();
    return {dac_code_out, ave_en, phase, sign, busy, done};
  endfunction

  function automatic logic [18:0] pack(input int dac, input bit a, input bit p,
                                       input bit s, input bit b, input bit d);
    logic [13:0] c;
    c = 14'(dac);
    return {c, a, p, s, b, d};
  endfunction

  function automatic int sat(input int v);
    if (v > 8191) return 8191;
    if (v < -8192) return -8192;
    return v;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] m;
    m = v[0] ? 16'hB400 : 16'h0000;
    return (v >> 1) ^ m;
  endfunction

  // driver: load a seed while idle
  task automatic load_seed(input logic [15:0] sd);
    seed_load = 1'b1;
    seed      = sd;
    @(negedge clk);
    seed_load = 1'b0;
    m_lfsr    = (sd == 16'h0) ? 16'hACE1 : sd;
    check($sformatf("seed_load %h", sd), 32'(dbg_lfsr), 32'(m_lfsr));
  endtask

  // driver: launch one sequence from IDLE (called at a negedge)
  task automatic run_seq(input string tag, input int base, input int delta,
                         input int off, input int tv, input int abort_at,
                         input bit noise, input bit ld, input logic [15:0] sd);
    int te, n, cp, cm, len;
    bit s;
    logic [18:0] e;
    te = (tv == 0) ? 1 : tv;
    n  = off + te;
    s  = m_lfsr[0];
    cp = sat(base + (s ? -delta : delta));
    cm = sat(base - (s ? -delta : delta));
    for (int k = 1; k <= n; k++) exp_q.push_back(pack(cp, k > off, 1'b0, s, 1'b1, 1'b0));
    for (int k = 1; k <= n; k++) exp_q.push_back(pack(cm, k > off, 1'b1, s, 1'b1, 1'b0));
    exp_q.push_back(pack(base, 1'b0, 1'b1, s, 1'b1, 1'b1));
    exp_q.push_back(pack(base, 1'b0, 1'b0, s, 1'b0, 1'b0));
    len = 2 * n + 2;
    last_base    = base;
    start        = 1'b1;
    base_code    = 14'(base);
    delta_code   = 14'(delta);
    timer_offset = 32'(off);
    time_value   = 32'(tv);
    if (ld) begin
      seed_load = 1'b1;
      seed      = sd;
      m_lfsr    = (sd == 16'h0) ? 16'hACE1 : sd;
    end
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      start     = 1'b0;
      seed_load = 1'b0;
      abort     = 1'b0;
      if (noise && k <= 2 * n + 1) begin
        start        = 1'($urandom_range(0, 1));
        seed_load    = 1'($urandom_range(0, 1));
        seed         = 16'($urandom);
        base_code    = 14'($urandom);
        delta_code   = 14'($urandom);
        timer_offset = 32'($urandom_range(0, 9));
        time_value   = 32'($urandom_range(0, 9));
      end
      e = exp_q.pop_front();
      check($sformatf("%s c%0d", tag, k), 32'(outs()), 32'(e));
      if (k == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        exp_q.delete();
        check($sformatf("%s abort", tag), 32'(outs()), 32'(pack(base, 1'b0, 1'b0, s, 1'b0, 1'b0)));
        check($sformatf("%s abort lfsr", tag), 32'(dbg_lfsr), 32'(m_lfsr));
        return;
      end
    end
    m_lfsr = lfsr_step(m_lfsr);
    check($sformatf("%s lfsr", tag), 32'(dbg_lfsr), 32'(m_lfsr));
  endtask

  initial begin
    int b, d;
    start = 0; abort = 0; seed_load = 0; seed = '0;
    timer_offset = '0; time_value = '0; base_code = '0; delta_code = '0;
    m_lfsr = 16'hACE1;
    last_base = 0;
    repeat (2) @(negedge clk);
    check("reset outs", 32'(outs()), 32'(0));
    check("reset lfsr", 32'(dbg_lfsr), 32'(16'hACE1));
    check("reset state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // asynchronous reset in the middle of HOLD_P
    start = 1'b1; timer_offset = 2; time_value = 8; base_code = 14'd500; delta_code = 14'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-reset hold", 32'(outs()), 32'(pack(480, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0)));
    #2 rst_n = 1'b0;
    #1;
    check("async reset outs", 32'(outs()), 32'(0));
    check("async reset lfsr", 32'(dbg_lfsr), 32'(16'hACE1));
    check("async reset state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_lfsr = 16'hACE1;

    // nominal sequence, sign 0
    load_seed(16'h0002);
    run_seq("nominal", 1000, 50, 2, 4, 0, 1'b0, 1'b0, 16'h0);

    // saturation on both rails
    load_seed(16'h0002);
    run_seq("sat hi", 8150, 100, 1, 2, 0, 1'b0, 1'b0, 16'h0);
    load_seed(16'h0001);
    run_seq("sat lo", -8150, 100, 1, 1, 0, 1'b0, 1'b0, 16'h0);

    // seed handling and sign sequence
    load_seed(16'h0000);
    for (int i = 0; i < 3; i++) begin
      b = int'($urandom_range(0, 16383)) - 8192;
      d = int'($urandom_range(0, 16383));
      run_seq($sformatf("rand%0d", i), b, d, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 4)), 0, 1'b0, 1'b0, 16'h0);
    end
    load_seed(16'h0001);
    check("seed1 sign bit", 32'(m_lfsr[0]), 32'(1));
    run_seq("seed1", 200, 30, 1, 2, 0, 1'b0, 1'b0, 16'h0);
    run_seq("seed+start", -300, 75, 1, 1, 0, 1'b0, 1'b1, 16'h0002);
    run_seq("after seed+start", 10, 5, 0, 2, 0, 1'b0, 1'b0, 16'h0);

    // zero offset and zero hold time
    run_seq("zero timing", 1234, 321, 0, 0, 0, 1'b0, 1'b0, 16'h0);

    // START/SEED_LOAD/data noise while busy
    run_seq("busy noise", -500, 400, 2, 3, 0, 1'b1, 1'b0, 16'h0);

    // ABORT in HOLD_M (off=1, tv=3: HOLD_M is cycles 6..8)
    run_seq("abort", 700, 60, 1, 3, 7, 1'b0, 1'b0, 16'h0);
    run_seq("post abort", 700, 60, 1, 3, 0, 1'b0, 1'b0, 16'h0);

    // ABORT in IDLE blocks START and changes nothing
    abort = 1'b1; start = 1'b1; base_code = 14'd99;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("idle abort outs", 32'(outs()),
          32'(pack(last_base, 1'b0, 1'b0, m_lfsr[0] ^ m_lfsr[0] ^ sign, 1'b0, 1'b0)));
    check("idle abort busy", 32'(busy), 32'(0));
    check("idle abort lfsr", 32'(dbg_lfsr), 32'(m_lfsr));
    run_seq("final", -4000, 4000, 1, 1, 0, 1'b0, 1'b0, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its summary in time");
    $fatal(1);
  end

endmodule
